// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter that shares one Avalon-MM PIO output slave among NUM_REQ requesters.
// Define READBACK_VERIFY_EN to add a readback cycle after each write and a sticky verify_err.
module pio_write_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 8,
    parameter logic [1:0]  PIO_ADDR = 2'd0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic [1:0]                avm_address,
    output logic                      avm_chipselect,
    output logic                      avm_write_n,
    output logic [31:0]               avm_writedata,
    input  logic [31:0]               avm_readdata,
    output logic [DATA_W-1:0]         shadow_value,
    output logic                      verify_err
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef READBACK_VERIFY_EN
    typedef enum logic [1:0] {StIdle, StWrite, StRead, StAck} state_e;
`else
    typedef enum logic [1:0] {StIdle, StWrite, StAck} state_e;
`endif

    state_e              state_q, state_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [IdxW-1:0]     win_q, win_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                cs_q, cs_d;
    logic                wn_q, wn_d;
    logic [1:0]          addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
`ifdef READBACK_VERIFY_EN
    logic                verr_q, verr_d;
`endif

    logic [DATA_W-1:0]   req_arr [NUM_REQ];
    logic                found;
    logic [IdxW-1:0]     pick;
    logic [IdxW-1:0]     cand_idx;
    int unsigned         cand;

    logic unused_readdata;
    assign unused_readdata = ^avm_readdata;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // First set request at or above the pointer, wrapping back to 0.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IdxW'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                pick  = cand_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        data_d   = data_q;
        ack_d    = '0;
        cs_d     = 1'b0;
        wn_d     = 1'b1;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        shadow_d = shadow_q;
`ifdef READBACK_VERIFY_EN
        verr_d   = verr_q;
`endif
        case (state_q)
            StIdle: begin
                if (found) begin
                    win_d   = pick;
                    data_d  = req_arr[pick];
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                    addr_d  = PIO_ADDR;
                    wdata_d = 32'(req_arr[pick]);
                    state_d = StWrite;
                end
            end
            StWrite: begin
                shadow_d = data_q;
`ifdef READBACK_VERIFY_EN
                cs_d     = 1'b1;
                addr_d   = PIO_ADDR;
                state_d  = StRead;
`else
                ack_d[win_q] = 1'b1;
                state_d      = StAck;
`endif
            end
`ifdef READBACK_VERIFY_EN
            StRead: begin
                if (avm_readdata[DATA_W-1:0] != data_q) begin
                    verr_d = 1'b1;
                end
                ack_d[win_q] = 1'b1;
                state_d      = StAck;
            end
`endif
            StAck: begin
                ptr_d   = (win_q == IdxW'(NUM_REQ - 1)) ? '0 : win_q + IdxW'(1);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            win_q    <= '0;
            data_q   <= '0;
            ack_q    <= '0;
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
            addr_q   <= 2'd0;
            wdata_q  <= '0;
            shadow_q <= '1;
`ifdef READBACK_VERIFY_EN
            verr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            cs_q     <= cs_d;
            wn_q     <= wn_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            shadow_q <= shadow_d;
`ifdef READBACK_VERIFY_EN
            verr_q   <= verr_d;
`endif
        end
    end

    assign ack            = ack_q;
    assign busy           = (state_q != StIdle);
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_writedata  = wdata_q;
    assign shadow_value   = shadow_q;
`ifdef READBACK_VERIFY_EN
    assign verify_err     = verr_q;
`else
    assign verify_err     = 1'b0;
`endif

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Scoreboard bench for pio_write_arbiter: expected writes/acks are queued by the stimulus and
// popped by a monitor whenever the bus writes or an ack pulses.
module tb_pio_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
`ifdef READBACK_VERIFY_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [NR-1:0]  req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  ack;
    logic           busy;
    logic [1:0]     avm_address;
    logic           avm_chipselect;
    logic           avm_write_n;
    logic [31:0]    avm_writedata;
    logic [31:0]    avm_readdata;
    logic [DW-1:0]  shadow_value;
    logic           verify_err;

    logic [7:0]     pio_out;
    logic           bad_slave;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int wr_cyc   = 0;

    logic [31:0]   exp_wr_q[$];
    logic [NR-1:0] exp_ack_q[$];

    always #5 clk = ~clk;

    pio_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .PIO_ADDR(2'd0)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_data       (req_data),
        .ack            (ack),
        .busy           (busy),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .shadow_value   (shadow_value),
        .verify_err     (verify_err)
    );

    // PIO slave: output register with reset value 0xFF, combinational readback.
    always @(posedge clk or posedge reset) begin
        if (reset) pio_out <= 8'hFF;
        else if (avm_chipselect && !avm_write_n && avm_address == 2'd0)
            pio_out <= avm_writedata[7:0];
    end
    assign avm_readdata = bad_slave ? 32'h0 : {24'h0, pio_out};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Monitor
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (avm_chipselect && !avm_write_n) begin
                if (exp_wr_q.size() == 0) check("unexpected write", avm_writedata, 32'hDEAD);
                else begin
                    check("write data", avm_writedata, exp_wr_q.pop_front());
                    check("write addr", 32'(avm_address), 32'h0);
                end
                wr_cyc = cyc;
            end
`ifndef READBACK_VERIFY_EN
            if (avm_chipselect && avm_write_n) check("unexpected read", 32'h1, 32'h0);
`endif
            if (ack != '0) begin
                if (exp_ack_q.size() == 0) check("unexpected ack", 32'(ack), 32'h0);
                else check("ack onehot", 32'(ack), 32'(exp_ack_q.pop_front()));
                check("ack latency", 32'(cyc - wr_cyc), 32'(LAT));
                check("cs during ack", 32'(avm_chipselect), 32'h0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_txn(input logic [7:0] d, input logic [NR-1:0] a);
        exp_wr_q.push_back({24'h0, d});
        exp_ack_q.push_back(a);
    endtask

    task automatic wait_acks(input int n, input string name);
        int seen = 0;
        int budget = 0;
        while (seen < n && budget < 100) begin
            step();
            budget++;
            if (ack != '0) seen++;
        end
        check(name, 32'(seen), 32'(n));
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        req_data = '0;
        bad_slave = 1'b0;
        repeat (2) step();
        check("rst shadow", 32'(shadow_value), 32'hFF);
        check("rst write_n", 32'(avm_write_n), 32'h1);
        check("rst cs", 32'(avm_chipselect), 32'h0);
        check("rst ack", 32'(ack), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst verr", 32'(verify_err), 32'h0);
        reset = 1'b0;
        step();

        // Contention: all held, pointer starts at 0.
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 8'h10 + 8'(i);
        expect_txn(8'h10, 4'b0001);
        expect_txn(8'h11, 4'b0010);
        expect_txn(8'h12, 4'b0100);
        expect_txn(8'h13, 4'b1000);
        expect_txn(8'h10, 4'b0001);
        req = 4'b1111;
        wait_acks(5, "contention acks");
        req = '0;
        step();

        // Single request.
        req_data[1*DW +: DW] = 8'h5A;
        expect_txn(8'h5A, 4'b0010);
        req = 4'b0010;
        step();
        check("busy in write", 32'(busy), 32'h1);
        wait_acks(1, "single ack");
        req = '0;
        check("single shadow", 32'(shadow_value), 32'h5A);
        check("single pio", 32'(pio_out), 32'h5A);
        step();
        check("idle busy", 32'(busy), 32'h0);

        // Early drop with data change after latching.
        req_data[0*DW +: DW] = 8'hA5;
        expect_txn(8'hA5, 4'b0001);
        req = 4'b0001;
        step();
        req = '0;
        req_data[0*DW +: DW] = 8'h00;
        wait_acks(1, "early drop ack");
        check("early shadow", 32'(shadow_value), 32'hA5);

        // Reset during WRITE: write observed, ack must never come.
        step();
        req_data[2*DW +: DW] = 8'h77;
        exp_wr_q.push_back(32'h77);
        req = 4'b0100;
        begin
            int b = 0;
            while (!avm_chipselect && b < 20) begin
                step();
                b++;
            end
        end
        check("reached write", 32'(avm_chipselect), 32'h1);
        reset = 1'b1;
        #1;
        check("async cs", 32'(avm_chipselect), 32'h0);
        check("async write_n", 32'(avm_write_n), 32'h1);
        check("async ack", 32'(ack), 32'h0);
        check("async busy", 32'(busy), 32'h0);
        check("async shadow", 32'(shadow_value), 32'hFF);
        req_data[0*DW +: DW] = 8'h21;
        req = 4'b0101;
        step();
        step();
        reset = 1'b0;
        // Pointer cleared: requester 0 beats requester 2.
        expect_txn(8'h21, 4'b0001);
        expect_txn(8'h77, 4'b0100);
        wait_acks(1, "post-reset ack0");
        req = 4'b0100;
        wait_acks(1, "post-reset ack2");
        req = '0;
        check("final shadow", 32'(shadow_value), 32'h77);
        check("final pio", 32'(pio_out), 32'h77);
        check("verr clean", 32'(verify_err), 32'h0);

`ifdef READBACK_VERIFY_EN
        step();
        bad_slave = 1'b1;
        req_data[3*DW +: DW] = 8'h3C;
        expect_txn(8'h3C, 4'b1000);
        req = 4'b1000;
        wait_acks(1, "verify ack");
        req = '0;
        step();
        check("verr set", 32'(verify_err), 32'h1);
`endif

        repeat (5) step();
        check("pending writes", 32'(exp_wr_q.size()), 32'h0);
        check("pending acks", 32'(exp_ack_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
